// File: rtl/led_rom_sequencer.sv
// Timed address sequencer for the LED pattern ROM: steps a read address through
// [ADDR_FIRST, ADDR_LAST] once per TICK_DIV clocks and latches each nibble onto leds.
module led_rom_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 4,
    parameter int TICK_DIV    = 50000000,
    parameter int ROM_LATENCY = 1,
    parameter int ADDR_FIRST  = 0,
    parameter int ADDR_LAST   = 4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] leds,
    output logic              busy,
    output logic              frame_done,
    output logic              wrap
);

    typedef enum logic [1:0] {IDLE, WAIT, READ, CAPT} state_t;

    localparam int                CNT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]  LAT_END = CNT_W'(ROM_LATENCY - 1);
    localparam logic [ADDR_W-1:0] A_FIRST = ADDR_W'(ADDR_FIRST);
    localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(ADDR_LAST);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                single_q, single_d;
    logic                rom_en_q, rom_en_d;
    logic [DATA_W-1:0]   leds_q, leds_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                wrap_q, wrap_d;
    logic                tick;
    logic                read_done;

    // READ is always entered with the tick counter at 0 (held in IDLE, wrapped by
    // the tick that leaves WAIT), so the frame counter doubles as the latency count.
    assign tick      = (cnt_q == CNT_MAX);
    assign read_done = (cnt_q == LAT_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= A_FIRST;
            single_q     <= 1'b0;
            rom_en_q     <= 1'b0;
            leds_q       <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            single_q     <= single_d;
            rom_en_q     <= rom_en_d;
            leds_q       <= leds_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            wrap_q       <= wrap_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        single_d = single_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d  = READ;
                    single_d = 1'b0;
                end else if (step) begin
                    state_d  = READ;
                    single_d = 1'b1;
                end
            end
            READ: begin
                if (read_done) state_d = CAPT;
            end
            CAPT: begin
                if (single_q || !run) begin
                    state_d  = IDLE;
                    single_d = 1'b0;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!run)      state_d = IDLE;
                else if (tick) state_d = READ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = (state_q == IDLE || tick) ? '0 : cnt_q + CNT_W'(1);
        addr_d       = addr_q;
        leds_d       = leds_q;
        frame_done_d = 1'b0;
        wrap_d       = 1'b0;
        if (state_q == CAPT) begin
            leds_d       = rom_data;
            frame_done_d = 1'b1;
            if (addr_q == A_LAST) begin
                addr_d = A_FIRST;
                wrap_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
        rom_en_d = (state_d == READ) || (state_d == CAPT);
        busy_d   = (state_d != IDLE);
    end

    assign rom_en     = rom_en_q;
    assign rom_addr   = addr_q;
    assign leds       = leds_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_led_rom_sequencer.sv
// Bench for led_rom_sequencer: two instances (ROM_LATENCY 1 and 2) share stimulus and
// are checked every cycle against a frame-phase model, plus literal timeline checks.
module tb_led_rom_sequencer;

    localparam int TICK  = 8;
    localparam int FIRST = 0;
    localparam int LAST  = 3;

    logic        clk, rst_n, run, step;
    logic        rom_en[2];
    logic [11:0] rom_addr[2];
    logic [3:0]  rom_data[2];
    logic [3:0]  leds[2];
    logic        busy[2], fd[2], wr[2];
    logic [3:0]  s1[2], s2[2];

    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    int nbusy[2];
    int nen[2];
    int e0[$], l0[$], w0[$], e1[$], l1[$];

    // model state: active flag, phase within frame, address, displayed leds
    bit         m_act[2], m_single[2], m_fd[2], m_wr[2];
    int         m_p[2], m_addr[2];
    logic [3:0] m_leds[2];

    led_rom_sequencer #(.ADDR_W(12), .DATA_W(4), .TICK_DIV(TICK), .ROM_LATENCY(1),
                        .ADDR_FIRST(FIRST), .ADDR_LAST(LAST)) u0 (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step),
        .rom_en(rom_en[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
        .leds(leds[0]), .busy(busy[0]), .frame_done(fd[0]), .wrap(wr[0]));

    led_rom_sequencer #(.ADDR_W(12), .DATA_W(4), .TICK_DIV(TICK), .ROM_LATENCY(2),
                        .ADDR_FIRST(FIRST), .ADDR_LAST(LAST)) u1 (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step),
        .rom_en(rom_en[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
        .leds(leds[1]), .busy(busy[1]), .frame_done(fd[1]), .wrap(wr[1]));

    function automatic logic [3:0] rom_tbl(input logic [11:0] a);
        case (a)
            12'd0:   rom_tbl = 4'd1;
            12'd1:   rom_tbl = 4'd2;
            12'd2:   rom_tbl = 4'd4;
            12'd3:   rom_tbl = 4'd8;
            default: rom_tbl = 4'd0;
        endcase
    endfunction

    // synchronous-read ROM; second stage models the DO register
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            s1[i] <= rom_en[i] ? rom_tbl(rom_addr[i]) : 4'd0;
            s2[i] <= s1[i];
        end
    end
    assign rom_data[0] = s1[0];
    assign rom_data[1] = s2[1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] <= 0; m_single[i] <= 0; m_fd[i] <= 0; m_wr[i] <= 0;
                m_p[i] <= 0; m_addr[i] <= FIRST; m_leds[i] <= 4'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_fd[i] <= 0;
                m_wr[i] <= 0;
                if (!m_act[i]) begin
                    if (run || step) begin
                        m_act[i] <= 1; m_p[i] <= 0; m_single[i] <= !run;
                    end
                end else if (m_p[i] < i + 1) begin
                    m_p[i] <= m_p[i] + 1;
                end else if (m_p[i] == i + 1) begin
                    m_leds[i] <= 4'(1 << (m_addr[i] - FIRST));
                    m_fd[i]   <= 1;
                    m_wr[i]   <= (m_addr[i] == LAST);
                    m_addr[i] <= (m_addr[i] == LAST) ? FIRST : m_addr[i] + 1;
                    if (m_single[i] || !run) m_act[i] <= 0;
                    else m_p[i] <= m_p[i] + 1;
                end else if (!run) begin
                    m_act[i] <= 0;
                end else begin
                    m_p[i] <= (m_p[i] + 1) % TICK;
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.rom_en", i), int'(rom_en[i]), int'(m_act[i] && m_p[i] <= i + 1));
            chk($sformatf("u%0d.rom_addr", i), int'(rom_addr[i]), m_addr[i]);
            chk($sformatf("u%0d.leds", i), int'(leds[i]), int'(m_leds[i]));
            chk($sformatf("u%0d.busy", i), int'(busy[i]), int'(m_act[i]));
            chk($sformatf("u%0d.frame_done", i), int'(fd[i]), int'(m_fd[i]));
            chk($sformatf("u%0d.wrap", i), int'(wr[i]), int'(m_wr[i]));
            if (busy[i]) nbusy[i]++;
            if (rom_en[i]) nen[i]++;
        end
        if (fd[0]) begin e0.push_back(edge_n); l0.push_back(int'(leds[0])); w0.push_back(int'(wr[0])); end
        if (fd[1]) begin e1.push_back(edge_n); l1.push_back(int'(leds[1])); end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
    endtask

    initial begin
        int k, n0, n1, b0, b1, en0, en1;
        int exp1[5];
        exp1 = '{1, 2, 4, 8, 1};
        for (int i = 0; i < 2; i++) begin nbusy[i] = 0; nen[i] = 0; end
        rst_n = 1'b0; run = 1'b0; step = 1'b0;
        cyc(3);
        chk("reset.leds", int'(leds[0]), 0);
        chk("reset.busy", int'(busy[0]), 0);
        chk("reset.rom_en", int'(rom_en[0]), 0);
        chk("reset.rom_addr", int'(rom_addr[0]), 0);
        rst_n = 1'b1;
        cyc(2);

        // continuous run: five frames, wrap on the load of 8
        n0 = e0.size(); n1 = e1.size();
        run = 1'b1; k = edge_n + 1;
        cyc(36);
        run = 1'b0;
        cyc(4);
        chk("run.frames_u0", e0.size() - n0, 5);
        chk("run.frames_u1", e1.size() - n1, 5);
        for (int j = 0; j < 5; j++) begin
            if (n0 + j < e0.size()) begin
                chk($sformatf("run.edge_u0[%0d]", j), e0[n0 + j], k + 2 + 8 * j);
                chk($sformatf("run.leds_u0[%0d]", j), l0[n0 + j], exp1[j]);
                chk($sformatf("run.wrap_u0[%0d]", j), w0[n0 + j], (j == 3) ? 1 : 0);
            end
            if (n1 + j < e1.size()) begin
                chk($sformatf("run.edge_u1[%0d]", j), e1[n1 + j], k + 3 + 8 * j);
                chk($sformatf("run.leds_u1[%0d]", j), l1[n1 + j], exp1[j]);
            end
        end

        // single-shot steps
        rst_pulse();
        n0 = e0.size(); b0 = nbusy[0]; b1 = nbusy[1]; en0 = nen[0]; en1 = nen[1];
        for (int j = 0; j < 3; j++) begin
            step = 1'b1;
            cyc(1);
            step = 1'b0;
            cyc(5);
        end
        chk("step.frames", e0.size() - n0, 3);
        for (int j = 0; j < 3; j++)
            if (n0 + j < e0.size()) chk($sformatf("step.leds[%0d]", j), l0[n0 + j], exp1[j]);
        chk("step.busy_u0", nbusy[0] - b0, 6);
        chk("step.busy_u1", nbusy[1] - b1, 9);
        chk("step.rom_en_u0", nen[0] - en0, 6);
        chk("step.rom_en_u1", nen[1] - en1, 9);
        chk("step.addr_kept", int'(rom_addr[0]), 3);

        // run dropped during CAPT of address 2, then resumed
        rst_pulse();
        run = 1'b1; k = edge_n + 1;
        cyc(18);
        run = 1'b0;
        chk("drop.capt_busy", int'(busy[0]), 1);
        chk("drop.capt_rom_en", int'(rom_en[0]), 1);
        cyc(1);
        chk("drop.leds", int'(leds[0]), 4);
        chk("drop.frame_done", int'(fd[0]), 1);
        chk("drop.idle", int'(busy[0]), 0);
        cyc(3);
        run = 1'b1;
        cyc(4);
        chk("resume.leds_u0", int'(leds[0]), 8);
        chk("resume.leds_u1", int'(leds[1]), 8);
        run = 1'b0;
        cyc(10);

        // reset during READ of address 2
        rst_pulse();
        run = 1'b1;
        cyc(17);
        chk("prerst.leds", int'(leds[0]), 2);
        rst_n = 1'b0;
        #1;
        chk("midrst.leds", int'(leds[0]), 0);
        chk("midrst.rom_en", int'(rom_en[0]), 0);
        chk("midrst.rom_addr", int'(rom_addr[0]), 0);
        chk("midrst.busy", int'(busy[0]), 0);
        chk("midrst.leds_u1", int'(leds[1]), 0);
        cyc(2);
        n0 = e0.size();
        rst_n = 1'b1; k = edge_n + 1;
        cyc(6);
        chk("postrst.frames", e0.size() - n0, 1);
        if (e0.size() > n0) begin
            chk("postrst.leds", l0[n0], 1);
            chk("postrst.edge", e0[n0], k + 2);
        end
        run = 1'b0;
        cyc(10);

        // step and run together: continuous mode
        rst_pulse();
        n0 = e0.size(); n1 = e1.size(); en0 = nen[0]; en1 = nen[1];
        step = 1'b1; run = 1'b1; k = edge_n + 1;
        cyc(1);
        step = 1'b0;
        cyc(20);
        chk("both.frames_u0", e0.size() - n0, 3);
        chk("both.frames_u1", e1.size() - n1, 3);
        chk("both.busy", int'(busy[0]), 1);
        chk("both.rom_en_u0", nen[0] - en0, 6);
        chk("both.rom_en_u1", nen[1] - en1, 9);
        if (e1.size() >= n1 + 3) begin
            chk("both.first_u1", e1[n1], k + 3);
            chk("both.period_u1", e1[n1 + 2] - e1[n1 + 1], 8);
        end
        run = 1'b0;
        cyc(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
